// File: rtl/sata_phy_pkg.sv
// Shared types and default timing for the SATA GTX reset/bring-up sequencer.
package sata_phy_pkg;

  typedef enum logic [2:0] {
    ST_CPLL_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_PMA       = 3'd2,
    ST_SATA_RST  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_READY     = 3'd5,
    ST_FAIL      = 3'd6
  } seq_state_t;

  // Default windows, in clk cycles. Every *_TIME value must be at least 1.
  localparam int CPLLRST_TIME_DEF    = 4;
  localparam int TXPMARESET_TIME_DEF = 1;
  localparam int RXEYERESET_TIME_DEF = 35;
  localparam int SATA_RST_TIME_DEF   = 8;
  localparam int PRST_TIME_DEF       = 8;

  // Width of the fixed-window down-counters in the sequencer.
  localparam int TMR_W = 16;

endpackage

// File: rtl/sata_prst_lane.sv
// One partial-reset channel for one lane: a rising request launches a fixed-width
// pulse, after which ack follows the lane's resetdone until the request drops.
module sata_prst_lane
  import sata_phy_pkg::*;
#(
  parameter int PRST_TIME = PRST_TIME_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req,
  input  logic done,
  output logic pulse,
  output logic ack
);

  localparam int            CW   = (PRST_TIME > 1) ? $clog2(PRST_TIME) : 1;
  localparam logic [CW-1:0] LOAD = CW'(PRST_TIME - 1);

  logic [CW-1:0] tmr;
  logic          req_d;
  logic          held;

  // Pulse timer and ack; a dropped request or a disabled channel clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr   <= '0;
      pulse <= 1'b0;
      ack   <= 1'b0;
      held  <= 1'b0;
      req_d <= 1'b0;
    end else begin
      req_d <= req;
      if (!en || !req) begin
        tmr   <= '0;
        pulse <= 1'b0;
        ack   <= 1'b0;
        held  <= 1'b0;
      end else if (!req_d) begin
        tmr   <= LOAD;
        pulse <= 1'b1;
        ack   <= 1'b0;
        held  <= 1'b0;
      end else if (pulse) begin
        if (tmr == '0) begin
          pulse <= 1'b0;
          held  <= 1'b1;
          ack   <= done;
        end else begin
          tmr <= tmr - 1'b1;
        end
      end else if (held) begin
        ack <= done;
      end
    end
  end

endmodule

// File: rtl/sata_phy_rst_seq.sv
// Reset/bring-up sequencer for NUM_LANES GTXE2 SATA lanes: CPLL reset, lock wait,
// PMA/eye reset windows, internal SATA reset, userrdy/resetdone handshake, bounded
// retries, plus per-lane TX PCS and RX partial resets served while READY.
module sata_phy_rst_seq
  import sata_phy_pkg::*;
#(
  parameter int NUM_LANES       = 1,
  parameter int CPLLRST_TIME    = CPLLRST_TIME_DEF,
  parameter int TXPMARESET_TIME = TXPMARESET_TIME_DEF,
  parameter int RXEYERESET_TIME = RXEYERESET_TIME_DEF,
  parameter int SATA_RST_TIME   = SATA_RST_TIME_DEF,
  parameter int PRST_TIME       = PRST_TIME_DEF,
  parameter int TIMEOUT_W       = 16,
  parameter int MAX_RETRIES     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cplllock,
  input  logic                 usrpll_locked,
  input  logic [NUM_LANES-1:0] txresetdone,
  input  logic [NUM_LANES-1:0] rxresetdone,
  input  logic [NUM_LANES-1:0] txpcsreset_req,
  input  logic [NUM_LANES-1:0] rxreset_req,
  output logic                 cpllreset,
  output logic [NUM_LANES-1:0] txreset,
  output logic [NUM_LANES-1:0] rxreset,
  output logic [NUM_LANES-1:0] txpcsreset,
  output logic [NUM_LANES-1:0] txuserrdy,
  output logic [NUM_LANES-1:0] rxuserrdy,
  output logic                 sata_rst,
  output logic                 gtx_ready,
  output logic                 gtx_configured,
  output logic [NUM_LANES-1:0] recal_tx_done,
  output logic [NUM_LANES-1:0] rxreset_ack,
  output logic                 fail,
  output logic [1:0]           retry_cnt
);

  localparam logic [TMR_W-1:0]     CPLL_LOAD = TMR_W'(CPLLRST_TIME - 1);
  localparam logic [TMR_W-1:0]     TX_LOAD   = TMR_W'(TXPMARESET_TIME - 1);
  localparam logic [TMR_W-1:0]     RX_LOAD   = TMR_W'(RXEYERESET_TIME - 1);
  localparam logic [TMR_W-1:0]     SATA_LOAD = TMR_W'(SATA_RST_TIME - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_MAX   = '1;
  localparam logic [1:0]           MAX_R     = 2'(MAX_RETRIES);

  seq_state_t           state;
  logic [TMR_W-1:0]     tmr;
  logic [TMR_W-1:0]     tx_tmr;
  logic [TMR_W-1:0]     rx_tmr;
  logic [TIMEOUT_W-1:0] tmo;
  logic [NUM_LANES-1:0] rxreset_full;
  logic [NUM_LANES-1:0] rx_pulse;
  logic                 locked;
  logic                 all_done;
  logic                 lost;
  logic                 expired;
  logic                 prst_en;

  // Lock loss is only a restart cause once lock has been seen; expiry only applies while waiting.
  always_comb begin
    locked   = cplllock & usrpll_locked;
    all_done = (&txresetdone) & (&rxresetdone);
    lost     = !locked && (state inside {ST_PMA, ST_SATA_RST, ST_WAIT_DONE, ST_READY});
    expired  = (tmo == TMO_MAX) &&
               (((state == ST_WAIT_LOCK) && !locked) ||
                ((state == ST_WAIT_DONE) && !all_done));
    prst_en  = gtx_configured && (state == ST_READY) && locked;
  end

  // Main sequencer: timers, retries and all registered GTX-facing controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_CPLL_RST;
      tmr            <= CPLL_LOAD;
      tx_tmr         <= '0;
      rx_tmr         <= '0;
      tmo            <= '0;
      cpllreset      <= 1'b1;
      txreset        <= '1;
      rxreset_full   <= '1;
      txuserrdy      <= '0;
      rxuserrdy      <= '0;
      sata_rst       <= 1'b0;
      gtx_ready      <= 1'b0;
      gtx_configured <= 1'b0;
      fail           <= 1'b0;
      retry_cnt      <= '0;
    end else begin
      tmo <= (tmo == TMO_MAX) ? tmo : tmo + 1'b1;
      if (lost || (expired && (retry_cnt != MAX_R))) begin
        state        <= ST_CPLL_RST;
        tmr          <= CPLL_LOAD;
        tmo          <= '0;
        cpllreset    <= 1'b1;
        txreset      <= '1;
        rxreset_full <= '1;
        txuserrdy    <= '0;
        rxuserrdy    <= '0;
        sata_rst     <= 1'b0;
        gtx_ready    <= 1'b0;
        if (!lost) retry_cnt <= retry_cnt + 2'd1;
      end else if (expired) begin
        state        <= ST_FAIL;
        tmo          <= '0;
        fail         <= 1'b1;
        cpllreset    <= 1'b1;
        txreset      <= '1;
        rxreset_full <= '1;
        txuserrdy    <= '0;
        rxuserrdy    <= '0;
      end else begin
        case (state)
          ST_CPLL_RST: begin
            if (tmr == '0) begin
              state     <= ST_WAIT_LOCK;
              tmo       <= '0;
              cpllreset <= 1'b0;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (locked) begin
              state        <= ST_PMA;
              tmo          <= '0;
              txreset      <= '0;
              rxreset_full <= '0;
              tx_tmr       <= TX_LOAD;
              rx_tmr       <= RX_LOAD;
            end
          end
          ST_PMA: begin
            if (tx_tmr != '0) tx_tmr <= tx_tmr - 1'b1;
            if (rx_tmr != '0) rx_tmr <= rx_tmr - 1'b1;
            if ((tx_tmr == '0) && (rx_tmr == '0)) begin
              state    <= ST_SATA_RST;
              tmo      <= '0;
              tmr      <= SATA_LOAD;
              sata_rst <= 1'b1;
            end
          end
          ST_SATA_RST: begin
            if (tmr == '0) begin
              state     <= ST_WAIT_DONE;
              tmo       <= '0;
              sata_rst  <= 1'b0;
              txuserrdy <= '1;
              rxuserrdy <= '1;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          ST_WAIT_DONE: begin
            if (all_done) begin
              state          <= ST_READY;
              tmo            <= '0;
              gtx_ready      <= 1'b1;
              gtx_configured <= 1'b1;
              retry_cnt      <= '0;
            end
          end
          ST_READY, ST_FAIL: begin
          end
          default: begin
            state     <= ST_CPLL_RST;
            tmr       <= CPLL_LOAD;
            tmo       <= '0;
            cpllreset <= 1'b1;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sata_prst_lane #(.PRST_TIME(PRST_TIME)) u_tx (
      .clk   (clk),
      .rst   (rst),
      .en    (prst_en),
      .req   (txpcsreset_req[i]),
      .done  (txresetdone[i]),
      .pulse (txpcsreset[i]),
      .ack   (recal_tx_done[i])
    );
    sata_prst_lane #(.PRST_TIME(PRST_TIME)) u_rx (
      .clk   (clk),
      .rst   (rst),
      .en    (prst_en),
      .req   (rxreset_req[i]),
      .done  (rxresetdone[i]),
      .pulse (rx_pulse[i]),
      .ack   (rxreset_ack[i])
    );
  end

  assign rxreset = rxreset_full | rx_pulse;

endmodule
